// File: rtl/hit_scan_engine_pkg.sv
// Shared definitions for the hit scan engine and its neighbours.
// Holds the scan FSM state type, the default sprite geometry and the
// coordinate widths that the duck drawers and shot builder also use.
// It also holds a small popcount helper used for the score update.
package hit_scan_engine_pkg;

  // Scan controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } scan_state_t;

  // Coordinate widths shared with the drawers and the shot builder.
  // X is signed so ducks can sit partly off the left edge.
  localparam int COORD_X_W = 11;
  localparam int COORD_Y_W = 10;

  // Default sprite boxes in pixels
  localparam int DUCK_BOX_W   = 40;
  localparam int DUCK_BOX_H   = 40;
  localparam int BULLET_BOX_W = 4;
  localparam int BULLET_BOX_H = 8;

  // Channel counts are limited to 16, so a 5-bit popcount is enough
  localparam int MAX_CHANNELS = 16;
  localparam int POP_W        = 5;

  function automatic logic [POP_W-1:0] popcount16(input logic [MAX_CHANNELS-1:0] v);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_CHANNELS; i++) begin
      cnt = cnt + POP_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/hit_scan_engine_aabb_overlap.sv
// aabb_overlap: purely combinational axis-aligned box overlap test.
// Box A (the target) sits at (a_x, a_y) with size A_W x A_H. Box B (the
// projectile) sits at (b_x, b_y) with size B_W x B_H. X is signed and Y is
// unsigned. Boxes whose edges only touch do not overlap.
// Ports:
//   a_x, a_y  target corner (signed X, unsigned Y)
//   b_x, b_y  projectile corner
//   hit       1 when the boxes share at least one pixel
module aabb_overlap
  import hit_scan_engine_pkg::*;
#(
  parameter int X_W = COORD_X_W,
  parameter int Y_W = COORD_Y_W,
  parameter int A_W = DUCK_BOX_W,
  parameter int A_H = DUCK_BOX_H,
  parameter int B_W = BULLET_BOX_W,
  parameter int B_H = BULLET_BOX_H
) (
  input  logic signed [X_W-1:0] a_x,
  input  logic        [Y_W-1:0] a_y,
  input  logic signed [X_W-1:0] b_x,
  input  logic        [Y_W-1:0] b_y,
  output logic                  hit
);

  // X uses one guard bit over the coordinate width. That is enough because
  // the box sizes are small compared with the coordinate range. Y gets two
  // extra bits. One bit is the zero-extension sign. The other bit absorbs
  // the carry when a box near the bottom of the Y range has its height added.
  localparam logic signed [X_W:0]   AW = (X_W+1)'(A_W);
  localparam logic signed [X_W:0]   BW = (X_W+1)'(B_W);
  localparam logic signed [Y_W+1:0] AH = (Y_W+2)'(A_H);
  localparam logic signed [Y_W+1:0] BH = (Y_W+2)'(B_H);

  logic signed [X_W:0]   ax;
  logic signed [X_W:0]   bx;
  logic signed [Y_W+1:0] ay;
  logic signed [Y_W+1:0] by;
  logic                  x_ov;
  logic                  y_ov;

  assign ax = {a_x[X_W-1], a_x};
  assign bx = {b_x[X_W-1], b_x};
  assign ay = {2'b00, a_y};
  assign by = {2'b00, b_y};

  // Strict compares, so edges that only touch do not count as overlap
  assign x_ov = (bx < ax + AW) && (bx + BW > ax);
  assign y_ov = (by < ay + AH) && (by + BH > ay);
  assign hit  = x_ov && y_ov;

endmodule

// File: rtl/hit_scan_engine.sv
// hit_scan_engine: once-per-frame collision scan of NUM_DUCKS targets
// against NUM_BULLETS bullets. A single shared comparator is used. One
// (duck, bullet) pair is tested per cycle, duck-major. Each duck can be hit
// at most once per scan, and each bullet can be consumed at most once.
// A saturating hit score is kept.
// Ports:
//   vga_clk       sole clock
//   reset         asynchronous active-low reset
//   frame_start   one-cycle pulse; starts a scan when idle
//   duck_x/y      packed duck positions (X signed), duck_alive mask
//   bullet_x/y    packed bullet positions (X signed), bullet_valid mask
//   hit_duck      one-cycle per-duck hit pulse, aligned with scan_done
//   bullet_kill   one-cycle per-bullet consume pulse, aligned with scan_done
//   scan_done     one-cycle pulse marking valid results
//   busy          high from the snapshot until the scan finishes
//   score         saturating total of hits (updates the cycle after scan_done)
//   missed_frame  sticky: frame_start arrived while busy
module hit_scan_engine
  import hit_scan_engine_pkg::*;
#(
  parameter int NUM_DUCKS   = 4,
  parameter int NUM_BULLETS = 8,
  parameter int X_W         = COORD_X_W,
  parameter int Y_W         = COORD_Y_W,
  parameter int DUCK_W      = DUCK_BOX_W,
  parameter int DUCK_H      = DUCK_BOX_H,
  parameter int BULLET_W    = BULLET_BOX_W,
  parameter int BULLET_H    = BULLET_BOX_H,
  parameter int SCORE_W     = 8
) (
  input  logic                         vga_clk,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic [NUM_DUCKS*X_W-1:0]     duck_x,
  input  logic [NUM_DUCKS*Y_W-1:0]     duck_y,
  input  logic [NUM_DUCKS-1:0]         duck_alive,
  input  logic [NUM_BULLETS*X_W-1:0]   bullet_x,
  input  logic [NUM_BULLETS*Y_W-1:0]   bullet_y,
  input  logic [NUM_BULLETS-1:0]       bullet_valid,
  output logic [NUM_DUCKS-1:0]         hit_duck,
  output logic [NUM_BULLETS-1:0]       bullet_kill,
  output logic                         scan_done,
  output logic                         busy,
  output logic [SCORE_W-1:0]           score,
  output logic                         missed_frame
);

  localparam int DI_W = (NUM_DUCKS   > 1) ? $clog2(NUM_DUCKS)   : 1;
  localparam int BI_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam int SUM_W = SCORE_W + POP_W;
  localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'({SCORE_W{1'b1}});

  scan_state_t state_reg, state_next;

  // Frame snapshot. Everything the scan reads comes from here.
  logic [NUM_DUCKS*X_W-1:0]   snap_duck_x_reg;
  logic [NUM_DUCKS*Y_W-1:0]   snap_duck_y_reg;
  logic [NUM_DUCKS-1:0]       snap_alive_reg;
  logic [NUM_BULLETS*X_W-1:0] snap_bullet_x_reg;
  logic [NUM_BULLETS*Y_W-1:0] snap_bullet_y_reg;
  logic [NUM_BULLETS-1:0]     snap_valid_reg;

  logic [DI_W-1:0]            d_idx_reg;
  logic [BI_W-1:0]            b_idx_reg;
  logic [NUM_DUCKS-1:0]       hitmask_reg;
  logic [NUM_BULLETS-1:0]     killmask_reg;

  logic [NUM_DUCKS-1:0]       hit_duck_reg;
  logic [NUM_BULLETS-1:0]     bullet_kill_reg;
  logic                       scan_done_reg;
  logic [SCORE_W-1:0]         score_reg;
  logic                       missed_reg;

  // Unpacked views of the snapshot, indexed by the scan counters
  logic signed [X_W-1:0] duck_x_arr   [NUM_DUCKS];
  logic        [Y_W-1:0] duck_y_arr   [NUM_DUCKS];
  logic signed [X_W-1:0] bullet_x_arr [NUM_BULLETS];
  logic        [Y_W-1:0] bullet_y_arr [NUM_BULLETS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DUCKS; gi++) begin : g_duck_unpack
      assign duck_x_arr[gi] = snap_duck_x_reg[gi*X_W +: X_W];
      assign duck_y_arr[gi] = snap_duck_y_reg[gi*Y_W +: Y_W];
    end
    for (gi = 0; gi < NUM_BULLETS; gi++) begin : g_bullet_unpack
      assign bullet_x_arr[gi] = snap_bullet_x_reg[gi*X_W +: X_W];
      assign bullet_y_arr[gi] = snap_bullet_y_reg[gi*Y_W +: Y_W];
    end
  endgenerate

  logic [NUM_DUCKS-1:0]   duck_sel;
  logic [NUM_BULLETS-1:0] bullet_sel;
  logic                   overlap;
  logic                   pair_match;
  logic                   last_pair;

  assign duck_sel   = NUM_DUCKS'(1)   << d_idx_reg;
  assign bullet_sel = NUM_BULLETS'(1) << b_idx_reg;
  assign last_pair  = (d_idx_reg == DI_W'(NUM_DUCKS - 1)) &&
                      (b_idx_reg == BI_W'(NUM_BULLETS - 1));

  aabb_overlap #(
    .X_W (X_W),
    .Y_W (Y_W),
    .A_W (DUCK_W),
    .A_H (DUCK_H),
    .B_W (BULLET_W),
    .B_H (BULLET_H)
  ) u_overlap (
    .a_x (duck_x_arr[d_idx_reg]),
    .a_y (duck_y_arr[d_idx_reg]),
    .b_x (bullet_x_arr[b_idx_reg]),
    .b_y (bullet_y_arr[b_idx_reg]),
    .hit (overlap)
  );

  // Claimed ducks and bullets are skipped. Because the scan order is fixed,
  // the lowest bullet index wins each duck. A bullet goes to the lowest duck
  // index it overlaps.
  assign pair_match = ((snap_alive_reg & duck_sel)     != '0) &&
                      ((snap_valid_reg & bullet_sel)   != '0) &&
                      ((hitmask_reg    & duck_sel)     == '0) &&
                      ((killmask_reg   & bullet_sel)   == '0) &&
                      overlap;

  // Score update. The hits are taken from the registered report pulse, so
  // the new total appears one cycle after scan_done.
  logic [SUM_W-1:0]   score_sum;
  logic [SCORE_W-1:0] score_next;

  always_comb begin
    score_sum  = SUM_W'(score_reg) +
                 SUM_W'(popcount16(MAX_CHANNELS'(hit_duck_reg)));
    score_next = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}}
                                         : score_sum[SCORE_W-1:0];
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (frame_start) state_next = SCAN;
      SCAN:    if (last_pair)   state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Snapshot, scan counters and pending masks
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      snap_duck_x_reg   <= '0;
      snap_duck_y_reg   <= '0;
      snap_alive_reg    <= '0;
      snap_bullet_x_reg <= '0;
      snap_bullet_y_reg <= '0;
      snap_valid_reg    <= '0;
      d_idx_reg         <= '0;
      b_idx_reg         <= '0;
      hitmask_reg       <= '0;
      killmask_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (frame_start) begin
            snap_duck_x_reg   <= duck_x;
            snap_duck_y_reg   <= duck_y;
            snap_alive_reg    <= duck_alive;
            snap_bullet_x_reg <= bullet_x;
            snap_bullet_y_reg <= bullet_y;
            snap_valid_reg    <= bullet_valid;
            d_idx_reg         <= '0;
            b_idx_reg         <= '0;
            hitmask_reg       <= '0;
            killmask_reg      <= '0;
          end
        end
        SCAN: begin
          if (pair_match) begin
            hitmask_reg  <= hitmask_reg  | duck_sel;
            killmask_reg <= killmask_reg | bullet_sel;
          end
          if (b_idx_reg == BI_W'(NUM_BULLETS - 1)) begin
            b_idx_reg <= '0;
            // Leaves d_idx at the last duck after the final pair; the next
            // frame_start reloads it anyway.
            if (!last_pair) d_idx_reg <= d_idx_reg + DI_W'(1);
          end else begin
            b_idx_reg <= b_idx_reg + BI_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Registered result pulses, score and overrun flag
  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      hit_duck_reg    <= '0;
      bullet_kill_reg <= '0;
      scan_done_reg   <= 1'b0;
      score_reg       <= '0;
      missed_reg      <= 1'b0;
    end else begin
      if (state_reg == REPORT) begin
        hit_duck_reg    <= hitmask_reg;
        bullet_kill_reg <= killmask_reg;
        scan_done_reg   <= 1'b1;
      end else begin
        hit_duck_reg    <= '0;
        bullet_kill_reg <= '0;
        scan_done_reg   <= 1'b0;
      end
      if (scan_done_reg) score_reg <= score_next;
      if (frame_start && (state_reg != IDLE)) missed_reg <= 1'b1;
    end
  end

  assign hit_duck     = hit_duck_reg;
  assign bullet_kill  = bullet_kill_reg;
  assign scan_done    = scan_done_reg;
  assign busy         = (state_reg != IDLE);
  assign score        = score_reg;
  assign missed_frame = missed_reg;

endmodule
